b2bcd_seq: RTL and testbench
============================

Name: b2bcd_seq

Overview:
- Iterative binary-to-BCD converter (shift-and-add-3), generalised successor of the combinational converter IP.
- Processes STEP bits per clock and trades latency for area.
- Adds an optional two's-complement signed mode, overflow detection, and valid/ready handshakes on both sides.
- Sits between arithmetic datapaths and display/output formatting logic.

Parameters:
- WIDTH, 8, binary input width (>=2).
- DIGIT, 3, number of BCD output digits (>=1).
- STEP, 1, bits consumed per cycle (1..WIDTH).
- Derived: ITER = ceil(WIDTH/STEP); PAD = ITER*STEP.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  converter can accept a word.
- Binary_code  in  WIDTH  binary input.
- sign_mode  in  1  1 = treat Binary_code as two's complement; sampled with the input.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  downstream accepts the result.
- BCD_code  out  DIGIT*4  result digits; digit k occupies bits [4k+3:4k].
- sign  out  1  1 = negative result (signed mode only).
- overflow  out  1  magnitude > 10^DIGIT - 1.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
  - On rst: state=IDLE, in_ready=1, out_valid=0, BCD_code=0, sign=0, overflow=0, iteration counter=0.
  - rst asserted mid-conversion or in DONE aborts the operation; the pending result is lost, not delivered.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch the operand, clear the BCD accumulator and overflow, go to CONV.
  - CONV: in_ready=0. Each cycle performs STEP dabble steps MSB-first. Counter runs 0..ITER-1; on the last iteration go to DONE.
  - DONE: out_valid=1, outputs stable. On out_ready go to IDLE next cycle. There is no input bypass: a new accept is possible at the earliest one cycle after the out handshake.
- Latency and throughput:
  - out_valid rises exactly ITER cycles after the accepting edge.
  - Minimum initiation interval is ITER+2 cycles.
- Operand preparation:
  - Unsigned: mag = Binary_code, zero-extended to PAD bits (leading zeros are harmless).
  - Signed with MSB=1: sign=1, mag = (~Binary_code + 1) taken as a WIDTH-bit unsigned value; the most negative value, e.g. -128 for WIDTH=8, gives mag = 2^(WIDTH-1) correctly.
  - Signed with MSB=0, or unsigned mode: sign=0.
- Dabble step, per bit:
  - Every digit >4 gets +3 (4-bit result).
  - Then {carry, digits} shift left by 1, with the next mag bit (MSB-first) entering digit 0's LSB.
  - The bit shifted out of the top digit is ORed into a sticky overflow.
  - On overflow, BCD_code = magnitude mod 10^DIGIT, which is exact by construction.
- Output stability: BCD_code, sign and overflow change only on entry to DONE or on rst. They hold their last values in IDLE/CONV; only out_valid qualifies them.
- Handshake rules:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored when out_valid=0.
  - Simultaneous in_valid and out_ready in DONE: the output is consumed, the input is not accepted that cycle.

Decomposition:
- Package b2bcd_pkg holds:
  - state encoding constants IDLE=2'd0, CONV=2'd1, DONE=2'd2;
  - function ceil_div(a,b) for ITER;
  - localparam for the BCD add-3 threshold (4) and addend (3).
- One combinational sub-module, b2bcd_step #(DIGIT): one add-3 plus shift-in-bit step with a carry-out port. It is instantiated STEP times in a chain inside b2bcd_seq.

Test Plan:
- WIDTH=8, DIGIT=3, STEP=1, unsigned 255 -> BCD_code=12'h255, overflow=0, out_valid exactly 8 cycles after accept.
- STEP=3, same input 8'd173 -> BCD_code=12'h173, latency ITER=3 cycles (PAD=9, one leading zero).
- sign_mode=1, input 8'h80 -> sign=1, BCD_code=12'h128. Input 8'hFF -> sign=1, BCD_code=12'h001.
- DIGIT=2, unsigned 255 -> BCD_code=8'h55, overflow=1. Input 99 -> BCD_code=8'h99, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and outputs stable, in_ready=0, in_valid pulses ignored. Release -> next accept no earlier than 1 cycle after the out handshake.
- Assert rst during the 4th CONV cycle -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0. A fresh conversion of 42 then yields 12'h042.

Source files
------------

// File: rtl/b2bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
package b2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] ADD3_THRESH = 4'd4;
    localparam logic [3:0] ADD3_ADDEND = 4'd3;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/b2bcd_step.sv
// One double-dabble step: add-3 correction on every digit, then shift in one bit.
module b2bcd_step
    import b2bcd_pkg::*;
#(
    parameter int DIGIT = 3
) (
    input  logic [DIGIT*4-1:0] bcd_i,
    input  logic               bit_i,
    output logic [DIGIT*4-1:0] bcd_o,
    output logic               carry_o
);

    logic [DIGIT*4-1:0] adj;
    logic [3:0]         d;

    always_comb begin
        adj = '0;
        d   = '0;
        for (int k = 0; k < DIGIT; k++) begin
            d = bcd_i[4*k +: 4];
            adj[4*k +: 4] = (d > ADD3_THRESH) ? d + ADD3_ADDEND : d;
        end
    end

    assign bcd_o   = {adj[DIGIT*4-2:0], bit_i};
    assign carry_o = adj[DIGIT*4-1];

endmodule

// File: rtl/b2bcd_seq.sv
// Iterative shift-and-add-3 converter, STEP bits per clock, optional signed input.
module b2bcd_seq
    import b2bcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 3,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   Binary_code,
    input  logic               sign_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIGIT*4-1:0] BCD_code,
    output logic               sign,
    output logic               overflow
);

    localparam int ITER = ceil_div(WIDTH, STEP);
    localparam int PAD  = ITER * STEP;
    localparam int DW   = DIGIT * 4;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t          state_q, state_d;
    logic [PAD-1:0]  mag_q, mag_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_acc_q, ovf_acc_d;
    logic            sgn_pend_q, sgn_pend_d;
    logic            sign_q, sign_d;
    logic            ovf_q, ovf_d;

    logic             op_neg;
    logic [WIDTH-1:0] op_mag;
    logic [DW-1:0]    chain [STEP+1];
    logic [STEP-1:0]  cout;
    logic             ovf_next;

    // Negating the most negative value wraps to 2^(WIDTH-1), which is the right magnitude.
    assign op_neg = sign_mode & Binary_code[WIDTH-1];
    assign op_mag = op_neg ? (~Binary_code + WIDTH'(1)) : Binary_code;

    assign chain[0] = acc_q;

    for (genvar s = 0; s < STEP; s++) begin : g_step
        b2bcd_step #(
            .DIGIT (DIGIT)
        ) u_step (
            .bcd_i   (chain[s]),
            .bit_i   (mag_q[PAD-1-s]),
            .bcd_o   (chain[s+1]),
            .carry_o (cout[s])
        );
    end

    assign ovf_next = ovf_acc_q | (|cout);

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_acc_d  = ovf_acc_q;
        sgn_pend_d = sgn_pend_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        ovf_d      = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mag_d      = PAD'(op_mag);
                    acc_d      = '0;
                    cnt_d      = '0;
                    ovf_acc_d  = 1'b0;
                    sgn_pend_d = op_neg;
                    state_d    = CONV;
                end
            end
            CONV: begin
                acc_d     = chain[STEP];
                mag_d     = mag_q << STEP;
                ovf_acc_d = ovf_next;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    bcd_d   = chain[STEP];
                    ovf_d   = ovf_next;
                    sign_d  = sgn_pend_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_acc_q  <= 1'b0;
            sgn_pend_q <= 1'b0;
            bcd_q      <= '0;
            sign_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_acc_q  <= ovf_acc_d;
            sgn_pend_q <= sgn_pend_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign BCD_code  = bcd_q;
    assign sign      = sign_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_b2bcd_seq.sv
// Directed bench for b2bcd_seq across three parameter sets.
module tb_b2bcd_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid  [3];
    logic       out_ready [3];
    logic [7:0] bin       [3];
    logic       smode     [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic [11:0] bcd      [3];
    logic       sgn       [3];
    logic       ovf       [3];
    logic [7:0] bcd2;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    b2bcd_seq #(.WIDTH(8), .DIGIT(3), .STEP(1)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .Binary_code(bin[0]), .sign_mode(smode[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .BCD_code(bcd[0]), .sign(sgn[0]), .overflow(ovf[0])
    );

    b2bcd_seq #(.WIDTH(8), .DIGIT(3), .STEP(3)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .Binary_code(bin[1]), .sign_mode(smode[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .BCD_code(bcd[1]), .sign(sgn[1]), .overflow(ovf[1])
    );

    b2bcd_seq #(.WIDTH(8), .DIGIT(2), .STEP(1)) u2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .Binary_code(bin[2]), .sign_mode(smode[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .BCD_code(bcd2), .sign(sgn[2]), .overflow(ovf[2])
    );

    assign bcd[2] = {4'h0, bcd2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic start(input int u, input logic [7:0] b, input logic sm);
        @(negedge clk);
        in_valid[u] = 1'b1;
        bin[u]      = b;
        smode[u]    = sm;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
    endtask

    task automatic wait_done(input int u, input int lat, input string tag);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid[u]) break;
        end
        chk({tag, "_lat"}, n, lat);
    endtask

    task automatic consume(input int u, input string tag);
        out_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[u] = 1'b0;
        chk({tag, "_ov_clr"}, out_valid[u], 0);
        chk({tag, "_ir_set"}, in_ready[u], 1);
    endtask

    task automatic run(input int u, input logic [7:0] b, input logic sm, input int lat,
                       input logic [11:0] eb, input logic es, input logic eo, input string tag);
        start(u, b, sm);
        wait_done(u, lat, tag);
        chk({tag, "_bcd"}, bcd[u], eb);
        chk({tag, "_sign"}, sgn[u], es);
        chk({tag, "_ovf"}, ovf[u], eo);
        consume(u, tag);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            bin[i]       = '0;
            smode[i]     = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ir", in_ready[i], 1);
            chk("rst_ov", out_valid[i], 0);
            chk("rst_bcd", bcd[i], 0);
            chk("rst_sign", sgn[i], 0);
            chk("rst_ovf", ovf[i], 0);
        end
        rst = 1'b0;

        run(0, 8'd255, 1'b0, 8, 12'h255, 1'b0, 1'b0, "u0_255");
        run(1, 8'd173, 1'b0, 3, 12'h173, 1'b0, 1'b0, "u1_173");
        run(1, 8'd255, 1'b0, 3, 12'h255, 1'b0, 1'b0, "u1_255");
        run(2, 8'd255, 1'b0, 8, 12'h055, 1'b0, 1'b1, "u2_255");
        run(2, 8'd99,  1'b0, 8, 12'h099, 1'b0, 1'b0, "u2_99");
        run(2, 8'h80,  1'b1, 8, 12'h028, 1'b1, 1'b1, "u2_neg128");

        // Backpressure: hold the result, poke in_valid, then release with a new word waiting.
        start(0, 8'd200, 1'b0);
        wait_done(0, 8, "bp");
        chk("bp_bcd", bcd[0], 12'h200);
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            bin[0]      = 8'(i * 11 + 1);
            @(posedge clk);
            #1;
            chk("bp_ov_hold", out_valid[0], 1);
            chk("bp_ir_low", in_ready[0], 0);
            chk("bp_bcd_hold", bcd[0], 12'h200);
        end
        bin[0]       = 8'd7;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        chk("bp_hs_ov", out_valid[0], 0);
        chk("bp_hs_ir", in_ready[0], 1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        chk("bp_acc_ir", in_ready[0], 0);
        chk("bp_conv_bcd", bcd[0], 12'h200);
        wait_done(0, 8, "bp7");
        chk("bp7_bcd", bcd[0], 12'h007);
        consume(0, "bp7");

        run(0, 8'h80, 1'b1, 8, 12'h128, 1'b1, 1'b0, "u0_neg128");
        run(0, 8'hFF, 1'b1, 8, 12'h001, 1'b1, 1'b0, "u0_neg1");
        run(0, 8'h7F, 1'b1, 8, 12'h127, 1'b0, 1'b0, "u0_pos127");

        // Reset in the 4th conversion cycle drops the operation.
        run(0, 8'hFF, 1'b1, 8, 12'h001, 1'b1, 1'b0, "u0_pre_rst");
        start(0, 8'd255, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_ir", in_ready[0], 1);
        chk("mid_rst_ov", out_valid[0], 0);
        chk("mid_rst_bcd", bcd[0], 0);
        chk("mid_rst_sign", sgn[0], 0);
        chk("mid_rst_ovf", ovf[0], 0);
        run(0, 8'd42, 1'b0, 8, 12'h042, 1'b0, 1'b0, "u0_42");

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
